// File: rtl/game_state_controller.sv
// rtl/game_state_controller.sv - level-flow FSM: title, playing, dying, game over, win
module game_state_controller #(
  parameter int unsigned DEATH_FRAMES     = 60,
  parameter int unsigned BLINK_PERIOD     = 8,
  parameter int unsigned DOOR_HOLD_FRAMES = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start_key,
  input  logic       player1_dead,
  input  logic       player2_dead,
  input  logic       player1_at_door,
  input  logic       player2_at_door,
  output logic [2:0] game_state,
  output logic       players_frozen,
  output logic       hazard_clear,
  output logic       death_blink,
  output logic [7:0] deaths_total
);

  typedef enum logic [2:0] {
    S_TITLE     = 3'd0,
    S_PLAYING   = 3'd1,
    S_DYING     = 3'd2,
    S_GAME_OVER = 3'd3,
    S_WIN       = 3'd4
  } state_e;

  localparam logic [7:0] DEATH_LIM = DEATH_FRAMES[7:0];
  localparam logic [7:0] BLINK_LIM = BLINK_PERIOD[7:0];
  localparam logic [7:0] DOOR_LIM  = DOOR_HOLD_FRAMES[7:0];

  state_e     state_q, state_d;
  logic       frame_prev_q, start_prev_q;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] door_cnt_q, door_cnt_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       blink_q, blink_d;
  logic       hclr_q, hclr_d;
  logic       frozen_q, frozen_d;
  logic [7:0] deaths_q, deaths_d;

  logic       tick, start;
  logic [7:0] frame_inc, door_inc, blink_inc, deaths_inc;

  // Edge detectors run off the previous-cycle samples so they are valid in the current cycle
  assign tick  = frame_clk & ~frame_prev_q;
  assign start = start_key & ~start_prev_q;

  // Counters never wrap; an increment at all-ones holds the value
  assign frame_inc  = (frame_cnt_q == 8'hFF) ? frame_cnt_q : frame_cnt_q + 8'd1;
  assign door_inc   = (door_cnt_q  == 8'hFF) ? door_cnt_q  : door_cnt_q  + 8'd1;
  assign blink_inc  = (blink_cnt_q == 8'hFF) ? blink_cnt_q : blink_cnt_q + 8'd1;
  assign deaths_inc = (deaths_q    == 8'hFF) ? deaths_q    : deaths_q    + 8'd1;

  // Next-state and registered-output logic for the level flow
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    door_cnt_d  = door_cnt_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    hclr_d      = 1'b0;
    deaths_d    = deaths_q;

    case (state_q)
      S_TITLE: begin
        if (start) begin
          state_d     = S_PLAYING;
          hclr_d      = 1'b1;
          frame_cnt_d = 8'd0;
          door_cnt_d  = 8'd0;
        end
      end
      S_PLAYING: begin
        if (player1_dead | player2_dead) begin
          // Death wins over a door completion in the same cycle
          state_d     = S_DYING;
          deaths_d    = deaths_inc;
          frame_cnt_d = 8'd0;
          door_cnt_d  = 8'd0;
          blink_cnt_d = 8'd0;
          blink_d     = 1'b1;
        end else if (player1_at_door & player2_at_door) begin
          if (tick) begin
            if (door_inc == DOOR_LIM) begin
              state_d     = S_WIN;
              door_cnt_d  = 8'd0;
              frame_cnt_d = 8'd0;
            end else begin
              door_cnt_d = door_inc;
            end
          end
        end else begin
          door_cnt_d = 8'd0;
        end
      end
      S_DYING: begin
        if (tick) begin
          if (frame_inc == DEATH_LIM) begin
            state_d     = S_GAME_OVER;
            frame_cnt_d = 8'd0;
            door_cnt_d  = 8'd0;
            blink_cnt_d = 8'd0;
          end else begin
            frame_cnt_d = frame_inc;
            if (blink_inc == BLINK_LIM) begin
              blink_d     = ~blink_q;
              blink_cnt_d = 8'd0;
            end else begin
              blink_cnt_d = blink_inc;
            end
          end
        end
      end
      S_GAME_OVER: begin
        if (start) begin
          state_d     = S_PLAYING;
          hclr_d      = 1'b1;
          frame_cnt_d = 8'd0;
          door_cnt_d  = 8'd0;
        end
      end
      S_WIN: begin
        if (start) begin
          state_d     = S_TITLE;
          frame_cnt_d = 8'd0;
          door_cnt_d  = 8'd0;
        end
      end
      default: begin
        state_d     = S_TITLE;
        frame_cnt_d = 8'd0;
        door_cnt_d  = 8'd0;
        blink_cnt_d = 8'd0;
      end
    endcase

    if (state_d != S_DYING) begin
      blink_d = 1'b0;
    end
    frozen_d = (state_d != S_PLAYING);
  end

  // State and output registers; start_prev resets high so a held key is not a press
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_TITLE;
      frame_prev_q <= 1'b0;
      start_prev_q <= 1'b1;
      frame_cnt_q  <= 8'd0;
      door_cnt_q   <= 8'd0;
      blink_cnt_q  <= 8'd0;
      blink_q      <= 1'b0;
      hclr_q       <= 1'b0;
      frozen_q     <= 1'b1;
      deaths_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      frame_prev_q <= frame_clk;
      start_prev_q <= start_key;
      frame_cnt_q  <= frame_cnt_d;
      door_cnt_q   <= door_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_q      <= blink_d;
      hclr_q       <= hclr_d;
      frozen_q     <= frozen_d;
      deaths_q     <= deaths_d;
    end
  end

  assign game_state     = state_q;
  assign players_frozen = frozen_q;
  assign hazard_clear   = hclr_q;
  assign death_blink    = blink_q;
  assign deaths_total   = deaths_q;

endmodule

// File: tb/tb_game_state_controller.sv
// tb/tb_game_state_controller.sv - scoreboard bench for game_state_controller
module tb_game_state_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic       start_key = 1'b1;
  logic       player1_dead = 1'b0;
  logic       player2_dead = 1'b0;
  logic       player1_at_door = 1'b0;
  logic       player2_at_door = 1'b0;
  logic [2:0] game_state;
  logic       players_frozen;
  logic       hazard_clear;
  logic       death_blink;
  logic [7:0] deaths_total;

  // Expected {game_state, hazard_clear, players_frozen} after the next clock
  typedef struct packed {
    logic [2:0] st;
    logic       hc;
    logic       fz;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   deaths_model = 0;

  game_state_controller #(
    .DEATH_FRAMES(60),
    .BLINK_PERIOD(8),
    .DOOR_HOLD_FRAMES(30)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_clk(frame_clk),
    .start_key(start_key),
    .player1_dead(player1_dead),
    .player2_dead(player2_dead),
    .player1_at_door(player1_at_door),
    .player2_at_door(player2_at_door),
    .game_state(game_state),
    .players_frozen(players_frozen),
    .hazard_clear(hazard_clear),
    .death_blink(death_blink),
    .deaths_total(deaths_total)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One frame: strobe high for one clock, low for one clock
  task automatic tick();
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    step();
  endtask

  // Leaves start_key high for the caller's next clock to be the press edge
  task automatic arm_start();
    start_key = 1'b0;
    step();
    start_key = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    start_key = 1'b1;
    repeat (3) step();
    total_cnt++;
    if ({game_state, hazard_clear, players_frozen, death_blink, deaths_total} !== {3'd0, 1'b0, 1'b1, 1'b0, 8'd0})
      $display("FAIL reset_state: got st=%0d hc=%0b fz=%0b bl=%0b d=%0d", game_state, hazard_clear, players_frozen, death_blink, deaths_total);
    else pass_cnt++;
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{st: 3'd0, hc: 1'b0, fz: 1'b1});
      step();
      e = exp_q.pop_front();
      total_cnt++;
      if ({game_state, hazard_clear, players_frozen} !== e)
        $display("FAIL held_key_no_start: got %b want %b", {game_state, hazard_clear, players_frozen}, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_start();
    arm_start();
    exp_q.push_back('{st: 3'd1, hc: 1'b1, fz: 1'b0});
    exp_q.push_back('{st: 3'd1, hc: 1'b0, fz: 1'b0});
    step();
    start_key = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      total_cnt++;
      if ({game_state, hazard_clear, players_frozen} !== e)
        $display("FAIL start_pulse[%0d]: got %b want %b", i, {game_state, hazard_clear, players_frozen}, e);
      else pass_cnt++;
      if (i == 0) step();
    end
  endtask

  // Enters DYING from PLAYING and runs the full death animation to GAME_OVER
  task automatic run_death(input bool_p1, input bit check_blink);
    if (bool_p1) player1_dead = 1'b1; else player2_dead = 1'b1;
    deaths_model = (deaths_model < 255) ? deaths_model + 1 : 255;
    exp_q.push_back('{st: 3'd2, hc: 1'b0, fz: 1'b1});
    step();
    player1_dead = 1'b0;
    player2_dead = 1'b0;
    e = exp_q.pop_front();
    total_cnt++;
    if ({game_state, hazard_clear, players_frozen} !== e || deaths_total !== 8'(deaths_model))
      $display("FAIL dying_entry: got %b d=%0d want %b d=%0d", {game_state, hazard_clear, players_frozen}, deaths_total, e, deaths_model);
    else pass_cnt++;
    for (int n = 1; n <= 60; n++) begin
      exp_q.push_back('{st: (n == 60) ? 3'd3 : 3'd2, hc: 1'b0, fz: 1'b1});
      tick();
      e = exp_q.pop_front();
      if (check_blink || n == 60) begin
        total_cnt++;
        if ({game_state, hazard_clear, players_frozen} !== e || death_blink !== ((n < 60) && ((n / 8) % 2 == 0)))
          $display("FAIL dying_tick%0d: got %b bl=%0b want %b bl=%0b", n, {game_state, hazard_clear, players_frozen}, death_blink, e, (n < 60) && ((n / 8) % 2 == 0));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_dying();
    run_death(1'b0, 1'b1);
  endtask

  task automatic test_restart();
    arm_start();
    exp_q.push_back('{st: 3'd1, hc: 1'b1, fz: 1'b0});
    step();
    start_key = 1'b0;
    e = exp_q.pop_front();
    total_cnt++;
    if ({game_state, hazard_clear, players_frozen} !== e || deaths_total !== 8'(deaths_model))
      $display("FAIL restart: got %b d=%0d want %b d=%0d", {game_state, hazard_clear, players_frozen}, deaths_total, e, deaths_model);
    else pass_cnt++;
    exp_q.push_back('{st: 3'd1, hc: 1'b0, fz: 1'b0});
    step();
    e = exp_q.pop_front();
    total_cnt++;
    if ({game_state, hazard_clear, players_frozen} !== e)
      $display("FAIL restart_pulse_len: got %b want %b", {game_state, hazard_clear, players_frozen}, e);
    else pass_cnt++;
  endtask

  task automatic test_door_win();
    player1_at_door = 1'b1;
    player2_at_door = 1'b1;
    for (int n = 1; n <= 29; n++) begin
      exp_q.push_back('{st: 3'd1, hc: 1'b0, fz: 1'b0});
      tick();
      e = exp_q.pop_front();
      total_cnt++;
      if ({game_state, hazard_clear, players_frozen} !== e)
        $display("FAIL door_run1_tick%0d: got %b want %b", n, {game_state, hazard_clear, players_frozen}, e);
      else pass_cnt++;
    end
    player1_at_door = 1'b0;
    step();
    player1_at_door = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      exp_q.push_back('{st: (n == 30) ? 3'd4 : 3'd1, hc: 1'b0, fz: (n == 30)});
      tick();
      e = exp_q.pop_front();
      total_cnt++;
      if ({game_state, hazard_clear, players_frozen} !== e)
        $display("FAIL door_run2_tick%0d: got %b want %b", n, {game_state, hazard_clear, players_frozen}, e);
      else pass_cnt++;
    end
    player1_at_door = 1'b0;
    player2_at_door = 1'b0;
    arm_start();
    exp_q.push_back('{st: 3'd0, hc: 1'b0, fz: 1'b1});
    exp_q.push_back('{st: 3'd0, hc: 1'b0, fz: 1'b1});
    for (int i = 0; i < 2; i++) begin
      step();
      start_key = 1'b0;
      e = exp_q.pop_front();
      total_cnt++;
      if ({game_state, hazard_clear, players_frozen} !== e)
        $display("FAIL win_to_title[%0d]: got %b want %b", i, {game_state, hazard_clear, players_frozen}, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_dead_priority();
    arm_start();
    step();
    start_key = 1'b0;
    player1_at_door = 1'b1;
    player2_at_door = 1'b1;
    repeat (29) tick();
    frame_clk = 1'b1;
    player1_dead = 1'b1;
    deaths_model = (deaths_model < 255) ? deaths_model + 1 : 255;
    exp_q.push_back('{st: 3'd2, hc: 1'b0, fz: 1'b1});
    step();
    frame_clk = 1'b0;
    player1_dead = 1'b0;
    player1_at_door = 1'b0;
    player2_at_door = 1'b0;
    e = exp_q.pop_front();
    total_cnt++;
    if ({game_state, hazard_clear, players_frozen} !== e || deaths_total !== 8'(deaths_model))
      $display("FAIL dead_over_win: got %b d=%0d want %b d=%0d", {game_state, hazard_clear, players_frozen}, deaths_total, e, deaths_model);
    else pass_cnt++;
    step();
    repeat (60) tick();
    total_cnt++;
    if (game_state !== 3'd3)
      $display("FAIL dead_over_win_gameover: got st=%0d want st=3", game_state);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 256; k++) begin
      test_restart();
      run_death(k[0], 1'b0);
    end
    total_cnt++;
    if (deaths_total !== 8'd255)
      $display("FAIL deaths_saturate: got %0d want 255", deaths_total);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_dying();
    test_restart();
    player2_dead = 1'b1;
    step();
    player2_dead = 1'b0;
    repeat (20) tick();
    #2;
    Reset = 1'b0;
    #1;
    total_cnt++;
    if ({game_state, players_frozen, death_blink, deaths_total} !== {3'd0, 1'b1, 1'b0, 8'd0})
      $display("FAIL async_reset_mid_dying: got st=%0d fz=%0b bl=%0b d=%0d want st=0 fz=1 bl=0 d=0", game_state, players_frozen, death_blink, deaths_total);
    else pass_cnt++;
    step();
    Reset = 1'b1;
    deaths_model = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_start();
    test_dying();
    test_restart();
    test_door_win();
    test_dead_priority();
    test_saturation();
    test_reset_mid_dying();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
